// File: rtl/report_collector_fifo.sv
// Tags CA processor reports with their symbol offset and buffers them in a FIFO; optional REPORT_DROP_CNT_EN adds drop_count.
// Latency: report event at edge N -> rec_valid in cycle N+1 when empty; symbol-to-report alignment is MATCH_LATENCY cycles.
// Backpressure: rec_ready low holds the head; reports arriving while full with no pop are dropped and flagged (sticky overflow).
module report_collector_fifo #(
    parameter int OFFSET_W      = 32,
    parameter int DEPTH         = 16,
    parameter int MATCH_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sym_valid,
    input  logic                       rpt_bt,
    input  logic [7:0]                 Activated_vector_t0,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [OFFSET_W-1:0]        rec_offset,
    output logic [7:0]                 rec_vector,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
`ifdef REPORT_DROP_CNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        logic [7:0]          vector;
    } rec_t;

    logic [OFFSET_W-1:0] sym_cnt;
    logic                pipe_vld [MATCH_LATENCY];
    logic [OFFSET_W-1:0] pipe_off [MATCH_LATENCY];

    rec_t                mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;

    logic d_valid;
    logic [OFFSET_W-1:0] d_offset;
    logic rpt_evt;
    logic full;
    logic pop;
    logic push;
    logic drop;
    rec_t head;

    // Offset counter and alignment pipeline; the pipeline shifts every cycle so
    // gaps in sym_valid travel through as invalid stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt <= '0;
            for (int i = 0; i < MATCH_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_off[i] <= '0;
            end
        end else begin
            if (sym_valid) begin
                sym_cnt <= sym_cnt + OFFSET_W'(1);
            end
            pipe_vld[0] <= sym_valid;
            pipe_off[0] <= sym_cnt;
            for (int i = 1; i < MATCH_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_off[i] <= pipe_off[i-1];
            end
        end
    end

    assign d_valid  = pipe_vld[MATCH_LATENCY-1];
    assign d_offset = pipe_off[MATCH_LATENCY-1];

    assign rpt_evt = d_valid & rpt_bt;
    assign full    = (count == CW'(DEPTH));
    assign pop     = rec_valid & rec_ready;
    assign push    = rpt_evt & (~full | pop);
    assign drop    = rpt_evt & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{offset: d_offset, vector: Activated_vector_t0};
        end
    end

    // When full, wr_ptr equals rd_ptr: a simultaneous pop vacates that slot on
    // the same edge, so the overwrite lands behind the new head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef REPORT_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign drop_count = drop_cnt;
`endif

    // Storage is not reset, so the head is masked to zero while empty.
    assign head       = rec_valid ? mem[rd_ptr] : '0;
    assign rec_valid  = (count != '0);
    assign rec_offset = head.offset;
    assign rec_vector = head.vector;
    assign fifo_count = count;

endmodule

// File: tb/tb_report_collector_fifo.sv
// Directed bench for report_collector_fifo: default instance plus a 4-bit offset instance for wrap behaviour.
module tb_report_collector_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        sym_valid;
    logic        rpt_bt;
    logic [7:0]  act_vec;
    logic        rec_ready;

    logic        rec_valid;
    logic [31:0] rec_offset;
    logic [7:0]  rec_vector;
    logic [4:0]  fifo_count;
    logic        overflow;

    logic        rec_valid4;
    logic [3:0]  rec_offset4;
    logic [7:0]  rec_vector4;
    logic [4:0]  fifo_count4;
    logic        overflow4;

`ifdef REPORT_DROP_CNT_EN
    logic [15:0] drop_count;
    logic [15:0] drop_count4;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    report_collector_fifo #(.OFFSET_W(32), .DEPTH(16), .MATCH_LATENCY(1)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .sym_valid           (sym_valid),
        .rpt_bt              (rpt_bt),
        .Activated_vector_t0 (act_vec),
        .rec_valid           (rec_valid),
        .rec_ready           (rec_ready),
        .rec_offset          (rec_offset),
        .rec_vector          (rec_vector),
        .fifo_count          (fifo_count),
        .overflow            (overflow)
`ifdef REPORT_DROP_CNT_EN
        ,
        .drop_count          (drop_count)
`endif
    );

    report_collector_fifo #(.OFFSET_W(4), .DEPTH(16), .MATCH_LATENCY(1)) u_dut4 (
        .clk                 (clk),
        .rst                 (rst),
        .sym_valid           (sym_valid),
        .rpt_bt              (rpt_bt),
        .Activated_vector_t0 (act_vec),
        .rec_valid           (rec_valid4),
        .rec_ready           (rec_ready),
        .rec_offset          (rec_offset4),
        .rec_vector          (rec_vector4),
        .fifo_count          (fifo_count4),
        .overflow            (overflow4)
`ifdef REPORT_DROP_CNT_EN
        ,
        .drop_count          (drop_count4)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        sym_valid = 1'b0;
        rpt_bt    = 1'b0;
        act_vec   = 8'h00;
        rec_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        compared += 5;
        if (rec_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rec_valid got %0b want 0", rec_valid); end
        if (fifo_count !== 5'd0) begin mismatched++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        if (rec_offset !== 32'd0) begin mismatched++; $display("FAIL reset_rec_offset got %0d want 0", rec_offset); end
        if (rec_vector !== 8'h00) begin mismatched++; $display("FAIL reset_rec_vector got %h want 00", rec_vector); end
`ifdef REPORT_DROP_CNT_EN
        compared++;
        if (drop_count !== 16'd0) begin mismatched++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
`endif
    endtask

    task automatic test_single_report;
        int vcycles;
        logic [31:0] off_seen;
        logic [7:0]  vec_seen;
        vcycles  = 0;
        off_seen = '1;
        vec_seen = 8'h00;
        do_reset();
        rec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sym_valid = (k < 6);
            rpt_bt    = (k == 4);
            act_vec   = (k == 4) ? 8'h84 : 8'h00;
            tick();
            if (rec_valid === 1'b1) begin
                vcycles++;
                off_seen = rec_offset;
                vec_seen = rec_vector;
            end
        end
        idle_inputs();
        compared += 4;
        if (vcycles != 1) begin mismatched++; $display("FAIL single_valid_cycles got %0d want 1", vcycles); end
        if (off_seen !== 32'd3) begin mismatched++; $display("FAIL single_offset got %0d want 3", off_seen); end
        if (vec_seen !== 8'h84) begin mismatched++; $display("FAIL single_vector got %h want 84", vec_seen); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL single_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_misaligned;
        do_reset();
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        tick();
        rpt_bt  = 1'b1;
        act_vec = 8'hFF;
        tick();
        tick();
        idle_inputs();
        tick();
        compared += 3;
        if (fifo_count !== 5'd0) begin mismatched++; $display("FAIL misaligned_count got %0d want 0", fifo_count); end
        if (rec_valid !== 1'b0) begin mismatched++; $display("FAIL misaligned_rec_valid got %0b want 0", rec_valid); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL misaligned_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_fill_overflow;
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            sym_valid = (k < 18);
            rpt_bt    = (k >= 1);
            act_vec   = 8'(k - 1);
            tick();
            if (k == 16) begin
                compared += 2;
                if (fifo_count !== 5'd16) begin mismatched++; $display("FAIL fill_count_at_full got %0d want 16", fifo_count); end
                if (overflow !== 1'b0) begin mismatched++; $display("FAIL fill_overflow_early got %0b want 0", overflow); end
            end
        end
        idle_inputs();
        tick();
        compared += 3;
        if (fifo_count !== 5'd16) begin mismatched++; $display("FAIL fill_count got %0d want 16", fifo_count); end
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL fill_overflow got %0b want 1", overflow); end
        if (rec_offset !== 32'd0) begin mismatched++; $display("FAIL fill_head_held got %0d want 0", rec_offset); end
`ifdef REPORT_DROP_CNT_EN
        compared++;
        if (drop_count !== 16'd2) begin mismatched++; $display("FAIL fill_drop_count got %0d want 2", drop_count); end
`endif
        rec_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            compared += 2;
            if (rec_valid !== 1'b1 || rec_offset !== 32'(i)) begin
                mismatched++;
                $display("FAIL drain_offset idx %0d got %0d (valid %0b) want %0d", i, rec_offset, rec_valid, i);
            end
            if (rec_vector !== 8'(i)) begin mismatched++; $display("FAIL drain_vector idx %0d got %h want %h", i, rec_vector, 8'(i)); end
            tick();
        end
        rec_ready = 1'b0;
        compared += 2;
        if (fifo_count !== 5'd0) begin mismatched++; $display("FAIL drain_count got %0d want 0", fifo_count); end
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL drain_overflow_sticky got %0b want 1", overflow); end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] exp_off;
        do_reset();
        for (int k = 0; k <= 41; k++) begin
            sym_valid = (k <= 40);
            rpt_bt    = ((k >= 1) && (k <= 16)) || (k == 41);
            act_vec   = (k == 41) ? 8'hAA : 8'(k - 1);
            rec_ready = (k == 41);
            tick();
        end
        idle_inputs();
        compared += 3;
        if (fifo_count !== 5'd16) begin mismatched++; $display("FAIL pushpop_count got %0d want 16", fifo_count); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL pushpop_overflow got %0b want 0", overflow); end
        if (rec_offset !== 32'd1) begin mismatched++; $display("FAIL pushpop_head got %0d want 1", rec_offset); end
        rec_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_off = (i < 15) ? 32'(i + 1) : 32'd40;
            compared++;
            if (rec_valid !== 1'b1 || rec_offset !== exp_off) begin
                mismatched++;
                $display("FAIL pushpop_drain idx %0d got %0d (valid %0b) want %0d", i, rec_offset, rec_valid, exp_off);
            end
            if (i == 15) begin
                compared++;
                if (rec_vector !== 8'hAA) begin mismatched++; $display("FAIL pushpop_last_vector got %h want aa", rec_vector); end
            end
            tick();
        end
        rec_ready = 1'b0;
        compared++;
        if (rec_valid !== 1'b0) begin mismatched++; $display("FAIL pushpop_empty got %0b want 0", rec_valid); end
    endtask

    task automatic test_offset_wrap;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            sym_valid = (k < 20);
            rpt_bt    = (k == 16) || (k == 17);
            act_vec   = (k == 16) ? 8'h0F : 8'h10;
            tick();
        end
        idle_inputs();
        compared += 3;
        if (fifo_count4 !== 5'd2) begin mismatched++; $display("FAIL wrap_count got %0d want 2", fifo_count4); end
        if (rec_offset4 !== 4'd15) begin mismatched++; $display("FAIL wrap_first_offset got %0d want 15", rec_offset4); end
        if (rec_vector4 !== 8'h0F) begin mismatched++; $display("FAIL wrap_first_vector got %h want 0f", rec_vector4); end
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        compared += 2;
        if (rec_offset4 !== 4'd0) begin mismatched++; $display("FAIL wrap_second_offset got %0d want 0", rec_offset4); end
        if (rec_vector4 !== 8'h10) begin mismatched++; $display("FAIL wrap_second_vector got %h want 10", rec_vector4); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int k = 0; k <= 17; k++) begin
            sym_valid = (k < 17);
            rpt_bt    = (k >= 1);
            act_vec   = 8'h55;
            tick();
        end
        idle_inputs();
        rec_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rec_ready = 1'b0;
        compared += 2;
        if (fifo_count !== 5'd5) begin mismatched++; $display("FAIL midrst_pre_count got %0d want 5", fifo_count); end
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL midrst_pre_overflow got %0b want 1", overflow); end
        sym_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sym_valid = 1'b0;
        compared += 3;
        if (rec_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_rec_valid got %0b want 0", rec_valid); end
        if (fifo_count !== 5'd0) begin mismatched++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
        if (overflow !== 1'b0) begin mismatched++; $display("FAIL midrst_overflow got %0b want 0", overflow); end
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        rpt_bt    = 1'b1;
        act_vec   = 8'h21;
        tick();
        idle_inputs();
        compared += 2;
        if (rec_valid !== 1'b1 || rec_offset !== 32'd0) begin
            mismatched++;
            $display("FAIL midrst_next_offset got %0d (valid %0b) want 0", rec_offset, rec_valid);
        end
        if (rec_vector !== 8'h21) begin mismatched++; $display("FAIL midrst_next_vector got %h want 21", rec_vector); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_report();
        test_misaligned();
        test_fill_overflow();
        test_full_push_pop();
        test_offset_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
